// File: rtl/dct2d_ctrl_pkg.sv
// Shared definitions for the 2-D 8x8 DCT sequencer: block geometry,
// bank-state encoding and the column-major address helper.
package dct_pkg;

  localparam int N      = 8;
  localparam int BLK    = N * N;
  localparam int ADDR_W = 6;
  localparam int LOG_N  = $clog2(N);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BLK - 1);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_t;

  // Swap the row and column fields so a linear count walks the block column by column.
  function automatic logic [ADDR_W-1:0] col_major(input logic [ADDR_W-1:0] cnt);
    return {cnt[LOG_N-1:0], cnt[ADDR_W-1:LOG_N]};
  endfunction

endpackage

// File: rtl/dct2d_ctrl_if.sv
// Handshake and transpose-memory / column-DCT control bundle of the DCT sequencer.
interface dct2d_ctrl_if;
  import dct_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              row_en;
  logic              tp_we;
  logic              tp_wbank;
  logic [ADDR_W-1:0] tp_waddr;
  logic              tp_re;
  logic              tp_rbank;
  logic [ADDR_W-1:0] tp_raddr;
  logic              col_en;
  logic              out_valid;
  logic              out_sof;
  logic              out_eof;
  logic              busy;

  modport master (
    input  in_valid,
    output in_ready, row_en,
    output tp_we, tp_wbank, tp_waddr,
    output tp_re, tp_rbank, tp_raddr,
    output col_en, out_valid, out_sof, out_eof, busy
  );

  modport slave (
    output in_valid,
    input  in_ready, row_en,
    input  tp_we, tp_wbank, tp_waddr,
    input  tp_re, tp_rbank, tp_raddr,
    input  col_en, out_valid, out_sof, out_eof, busy
  );

endinterface

// File: rtl/dct2d_ctrl_delay_line.sv
// Fixed-depth shift register with synchronous clear; also reports whether
// any stage still holds a set bit so the top can tell the pipe is empty.
module dct_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             pending
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one stage per clock; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  // OR-reduce every stage.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) pending = pending | (|stage[i]);
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/dct2d_ctrl.sv
// Sequencer for row DCT -> ping-pong transpose memory -> column DCT.
//
// Per-bank state:
//   state   | meaning
//   FREE    | empty, may accept a new block
//   FILLING | samples being accepted / row results being written
//   FULL    | all 64 row results written, waiting for the read side
//   READING | 64 column-major reads in progress
module dct2d_ctrl
  import dct_pkg::*;
#(
  parameter int ROW_LAT   = 8,
  parameter int COL_LAT   = 8,
  parameter int TP_RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  dct2d_ctrl_if.master bus
);

  bank_state_t       bank_st [2];
  logic              acc_bank, wr_bank, rd_bank;
  logic [ADDR_W-1:0] acc_cnt, wr_cnt, rd_cnt;

  logic       in_ready, fire, rd_start, rd_on, tp_we;
  logic       we_pend, col_pend, out_pend;
  logic [2:0] rd_tag, col_tag, out_tag;

  assign in_ready = (bank_st[acc_bank] == FREE) || (acc_cnt != '0);
  assign fire     = bus.in_valid && in_ready;
  assign rd_start = (bank_st[rd_bank] == FULL);
  assign rd_on    = rd_start || (bank_st[rd_bank] == READING);

  // {valid, sof, eof} travels with each read through memory and column DCT.
  assign rd_tag = {rd_on, rd_on && (rd_cnt == '0), rd_on && (rd_cnt == LAST_IDX)};

  // Bank occupancy plus accept/write/read counters; the three sides may
  // touch different banks in the same cycle and all updates apply.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st[0] <= FREE;
      bank_st[1] <= FREE;
      acc_bank   <= 1'b0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      acc_cnt    <= '0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
    end else begin
      if (fire) begin
        acc_cnt <= acc_cnt + ADDR_W'(1);
        if (acc_cnt == '0) bank_st[acc_bank] <= FILLING;
        if (acc_cnt == LAST_IDX) acc_bank <= ~acc_bank;
      end
      if (tp_we) begin
        wr_cnt <= wr_cnt + ADDR_W'(1);
        if (wr_cnt == LAST_IDX) begin
          bank_st[wr_bank] <= FULL;
          wr_bank          <= ~wr_bank;
        end
      end
      if (rd_on) begin
        rd_cnt <= rd_cnt + ADDR_W'(1);
        if (rd_start) bank_st[rd_bank] <= READING;
        if (rd_cnt == LAST_IDX) begin
          bank_st[rd_bank] <= FREE;
          rd_bank          <= ~rd_bank;
        end
      end
    end
  end

  dct_delay_line #(.DEPTH(ROW_LAT), .WIDTH(1)) u_we_dly (
    .clk(clk), .rst(rst), .d(fire), .q(tp_we), .pending(we_pend)
  );

  dct_delay_line #(.DEPTH(TP_RD_LAT), .WIDTH(3)) u_rd_dly (
    .clk(clk), .rst(rst), .d(rd_tag), .q(col_tag), .pending(col_pend)
  );

  dct_delay_line #(.DEPTH(COL_LAT), .WIDTH(3)) u_col_dly (
    .clk(clk), .rst(rst), .d(col_tag), .q(out_tag), .pending(out_pend)
  );

  assign bus.in_ready  = in_ready;
  assign bus.row_en    = fire;
  assign bus.tp_we     = tp_we;
  assign bus.tp_wbank  = wr_bank;
  assign bus.tp_waddr  = wr_cnt;
  assign bus.tp_re     = rd_on;
  assign bus.tp_rbank  = rd_bank;
  assign bus.tp_raddr  = col_major(rd_cnt);
  assign bus.col_en    = col_tag[2];
  assign bus.out_valid = out_tag[2];
  assign bus.out_sof   = out_tag[1];
  assign bus.out_eof   = out_tag[0];
  assign bus.busy      = (bank_st[0] != FREE) || (bank_st[1] != FREE) ||
                         we_pend || col_pend || out_pend;

endmodule

// File: tb/tb_dct2d_ctrl.sv
// Self-checking bench for dct2d_ctrl: block-level timing model with per-cycle compare.
module tb_dct2d_ctrl;
  import dct_pkg::*;

  localparam int ROW_LAT   = 8;
  localparam int COL_LAT   = 8;
  localparam int TP_RD_LAT = 1;
  localparam int NC        = 4096;
  localparam int MAXB      = 16;
  localparam int BUDGET    = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dct2d_ctrl_if bus();

  dct2d_ctrl #(.ROW_LAT(ROW_LAT), .COL_LAT(COL_LAT), .TP_RD_LAT(TP_RD_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: accept count, per-block first-accept and read-start cycles,
  // and per-cycle expected strobes scheduled when accepts happen.
  int cyc, m_acc, m_last;
  int a0 [MAXB];
  int rk [MAXB];
  bit e_we [NC], e_wbank [NC], e_re [NC], e_rbank [NC];
  bit e_col [NC], e_ov [NC], e_sof [NC], e_eof [NC];
  logic [5:0] e_waddr [NC], e_raddr [NC];

  // Observations from the DUT for literal end-of-phase checks.
  int ov_count, first_ov, nws, nrs;
  int wseq [8];
  int rseq [8];
  bit rh [NC];
  bit er;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      e_we[i] = 0; e_wbank[i] = 0; e_re[i] = 0; e_rbank[i] = 0;
      e_col[i] = 0; e_ov[i] = 0; e_sof[i] = 0; e_eof[i] = 0;
      e_waddr[i] = '0; e_raddr[i] = '0;
    end
    for (int b = 0; b < MAXB; b++) begin a0[b] = -1; rk[b] = -1; end
    cyc = 0; m_acc = 0; m_last = 0;
    ov_count = 0; first_ov = -1; nws = 0; nrs = 0;
  endtask

  // Sample k*64+i accepted at t: written ROW_LAT later; a finished block is
  // read once written and once the previous block's 64 reads are over.
  task automatic model_accept(input int t);
    int k, i, w, r, c;
    k = m_acc / 64;
    i = m_acc % 64;
    if (k < MAXB) begin
      if (i == 0) a0[k] = t;
      w = t + ROW_LAT;
      if (w < NC) begin
        e_we[w] = 1; e_waddr[w] = 6'(i); e_wbank[w] = ((k % 2) == 1);
      end
      if (i == 63) begin
        r = w + 1;
        if (k > 0 && rk[k-1] + 64 > r) r = rk[k-1] + 64;
        rk[k] = r;
        for (int j = 0; j < 64; j++) begin
          c = r + j;
          if (c + TP_RD_LAT + COL_LAT < NC) begin
            e_re[c] = 1;
            e_raddr[c] = 6'((j % 8) * 8 + j / 8);
            e_rbank[c] = ((k % 2) == 1);
            e_col[c + TP_RD_LAT] = 1;
            e_ov[c + TP_RD_LAT + COL_LAT] = 1;
            e_sof[c + TP_RD_LAT + COL_LAT] = (j == 0);
            e_eof[c + TP_RD_LAT + COL_LAT] = (j == 63);
          end
        end
        m_last = r + 63 + TP_RD_LAT + COL_LAT;
      end
    end
    m_acc++;
  endtask

  // A new block may start only in a bank whose previous occupant (two blocks back) is fully read.
  function automatic bit model_ready(input int t);
    int k, i;
    k = m_acc / 64;
    i = m_acc % 64;
    if (i != 0 || k < 2) return 1'b1;
    return (rk[k-2] + 63 < t);
  endfunction

  // Busy from the cycle after a block's first accept until its last output.
  function automatic bit model_busy(input int t);
    int nb;
    nb = (m_acc + 63) / 64;
    for (int k = 0; k < nb && k < MAXB; k++)
      if (a0[k] < t && (rk[k] < 0 || t <= rk[k] + 63 + TP_RD_LAT + COL_LAT)) return 1'b1;
    return 1'b0;
  endfunction

  // Compare process: checks every output each cycle, then advances the model.
  always @(negedge clk) begin
    if (rst) begin
      model_reset();
    end else if (cyc < NC) begin
      er = model_ready(cyc);
      chk("in_ready", bus.in_ready, er);
      chk("row_en", bus.row_en, bus.in_valid & er);
      chk("busy", bus.busy, model_busy(cyc));
      chk("tp_we", bus.tp_we, e_we[cyc]);
      if (e_we[cyc]) begin
        chk("tp_waddr", bus.tp_waddr, e_waddr[cyc]);
        chk("tp_wbank", bus.tp_wbank, e_wbank[cyc]);
      end
      chk("tp_re", bus.tp_re, e_re[cyc]);
      if (e_re[cyc]) begin
        chk("tp_raddr", bus.tp_raddr, e_raddr[cyc]);
        chk("tp_rbank", bus.tp_rbank, e_rbank[cyc]);
      end
      chk("col_en", bus.col_en, e_col[cyc]);
      chk("out_valid", bus.out_valid, e_ov[cyc]);
      chk("out_sof", bus.out_sof, e_sof[cyc]);
      chk("out_eof", bus.out_eof, e_eof[cyc]);
      tests++;
      assert (!(bus.tp_we && bus.tp_re && bus.tp_wbank == bus.tp_rbank)) else begin
        fails++;
        $display("FAIL no_write_to_reading_bank cyc=%0d got=bank%0d expected=other", cyc, bus.tp_wbank);
      end

      rh[cyc] = bus.in_ready;
      if (bus.out_valid) begin
        ov_count++;
        if (first_ov < 0) first_ov = cyc;
      end
      if (bus.tp_we && bus.tp_waddr == 6'd0 && nws < 8) begin wseq[nws] = bus.tp_wbank; nws++; end
      if (bus.tp_re && bus.tp_raddr == 6'd0 && nrs < 8) begin rseq[nrs] = bus.tp_rbank; nrs++; end

      if (bus.in_valid && er) model_accept(cyc);
      cyc++;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // mode 0: always valid, 1: toggle, 2: random with dens percent.
  task automatic run_phase(input int mode, input int dens, input int target, input int rst_at);
    int n;
    bit done_rst;
    do_reset();
    n = 0;
    done_rst = 0;
    while (!(m_acc >= target && cyc > m_last + 2) && n < BUDGET) begin
      if (!done_rst && rst_at >= 0 && cyc == rst_at) begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        done_rst = 1;
      end else begin
        rst = 1'b0;
        case (mode)
          0: bus.in_valid = (m_acc < target);
          1: bus.in_valid = (m_acc < target) && (cyc % 2 == 0);
          default: bus.in_valid = (m_acc < target) && ($urandom_range(0, 99) < dens);
        endcase
      end
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    chk("phase_done", int'(n < BUDGET), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;

    // One block from cycle 0.
    run_phase(0, 0, 64, -1);
    chk("m_rd_start", rk[0], 72);
    chk("m_we7", e_we[7], 0);
    chk("m_we8", e_we[8], 1);
    chk("m_we71", e_we[71], 1);
    chk("m_we72", e_we[72], 0);
    chk("m_raddr73", e_raddr[73], 8);
    chk("m_raddr80", e_raddr[80], 1);
    chk("m_sof81", e_sof[81], 1);
    chk("m_eof144", e_eof[144], 1);
    chk("m_ov145", e_ov[145], 0);
    chk("first_ov", first_ov, 81);
    chk("ov_count1", ov_count, 64);

    // Three blocks streamed back to back.
    run_phase(0, 0, 192, -1);
    chk("ready127", rh[127], 1);
    chk("ready128", rh[128], 0);
    chk("ready135", rh[135], 0);
    chk("ready136", rh[136], 1);
    chk("ov_count3", ov_count, 192);

    // Valid toggling every cycle.
    run_phase(1, 0, 64, -1);
    chk("m_rd_start_toggle", rk[0], 135);
    chk("ov_count_toggle", ov_count, 64);

    // Random gaps over four blocks; bank alternation.
    run_phase(2, 70, 256, -1);
    chk("nws", nws, 4);
    chk("nrs", nrs, 4);
    for (int i = 0; i < 4; i++) begin
      chk("wbank_seq", wseq[i], i % 2);
      chk("rbank_seq", rseq[i], i % 2);
    end
    chk("ov_count_rand", ov_count, 256);

    // Reset mid-block, then a fresh block.
    run_phase(0, 0, 64, 40);
    chk("first_ov_after_rst", first_ov - a0[0], 81);
    chk("ov_count_rst", ov_count, 64);

    // More random traffic, sparse and dense.
    run_phase(2, 35, 128, -1);
    run_phase(2, 95, 320, -1);
    chk("ov_count_dense", ov_count, 320);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
